// File: rtl/alu_issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// issue_pkg
// Shared types and default sizes for the ALU issue queue.
//   iq_entry_t  : payload held per queue entry and presented at issue
//   psrc_t      : source operand tag {valid, id}
//   wake_req_t  : one wakeup broadcast {valid, preg}
//   iq_cnt_t    : occupancy count type for the default queue depth
// -----------------------------------------------------------------------------
package issue_pkg;

    localparam int IQ_DEPTH     = 8;
    localparam int FETCH_WIDTH  = 2;
    localparam int ALU_WAKE_NUM = 2;

    localparam int PREG_W = 6;
    localparam int ROB_W  = 5;
    localparam int PC_W   = 32;
    localparam int CTL_W  = 8;

    typedef logic [PREG_W-1:0] preg_addr_t;
    typedef logic [ROB_W-1:0]  rob_ptr_t;

    typedef struct packed {
        logic       valid;
        preg_addr_t id;
    } psrc_t;

    typedef struct packed {
        psrc_t            psrc1;
        psrc_t            psrc2;
        preg_addr_t       pdst;
        rob_ptr_t         rob_ptr;
        logic [PC_W-1:0]  pc;
        logic [CTL_W-1:0] ctl;
    } iq_entry_t;

    typedef struct packed {
        logic       valid;
        preg_addr_t preg;
    } wake_req_t;

    // Count must be able to hold the value IQ_DEPTH itself (queue full).
    localparam int IQ_CNT_W = $clog2(IQ_DEPTH + 1);
    typedef logic [IQ_CNT_W-1:0] iq_cnt_t;

endpackage

// File: rtl/alu_issue_queue_select.sv
// -----------------------------------------------------------------------------
// iq_select
// Priority find-first over the eligible vector: the lowest set index wins,
// which in a collapsing queue is the oldest ready entry.
//   eligible : per-entry eligibility
//   idx      : index of the lowest eligible entry (0 when none)
//   found    : at least one entry is eligible
// -----------------------------------------------------------------------------
module iq_select #(
    parameter  int N  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan from the top down so that the last hit written is the lowest index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// -----------------------------------------------------------------------------
// alu_issue_queue
// Collapsing in-order-age issue queue for the ALU pipe. Entry 0 is the oldest;
// valid entries are contiguous from index 0. Each cycle the oldest entry with
// both sources ready is offered downstream; on acceptance it is removed and the
// entries above it shift down, then new dispatches are appended at the tail.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   flush                 : branch-miss flush, empties the queue
//   disp_valid/disp_entry : per-slot dispatch from the rename stage
//   rdy_v1, rdy_v2        : source-ready bits returned for the dispatching slots
//   rdy_psrc1, rdy_psrc2  : source tags sent out for that ready lookup
//   wake_valid/wake_preg  : wakeup broadcasts
//   issue_ready           : downstream accepts the offered entry
//   issue_valid/issue_entry : offered entry (combinational from stored state)
//   iq_full               : dispatch is blocked (from registered count)
//   count                 : current occupancy (debug/observation)
//
// Handshake: an entry leaves the queue at a rising edge exactly when
// issue_valid && issue_ready are both high in the preceding cycle; otherwise
// the same entry stays offered. Dispatch is accepted whenever iq_full is low
// and no flush is present, with no ready signal back to the sender.
// -----------------------------------------------------------------------------
module alu_issue_queue
    import issue_pkg::*;
#(
    parameter int IQ_DEPTH     = issue_pkg::IQ_DEPTH,
    parameter int FETCH_WIDTH  = issue_pkg::FETCH_WIDTH,
    parameter int ALU_WAKE_NUM = issue_pkg::ALU_WAKE_NUM
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [FETCH_WIDTH-1:0]              disp_valid,
    input  iq_entry_t [FETCH_WIDTH-1:0]         disp_entry,
    input  logic [FETCH_WIDTH-1:0]              rdy_v1,
    input  logic [FETCH_WIDTH-1:0]              rdy_v2,
    output preg_addr_t [FETCH_WIDTH-1:0]        rdy_psrc1,
    output preg_addr_t [FETCH_WIDTH-1:0]        rdy_psrc2,
    input  logic [ALU_WAKE_NUM-1:0]             wake_valid,
    input  preg_addr_t [ALU_WAKE_NUM-1:0]       wake_preg,
    input  logic                                issue_ready,
    output logic                                issue_valid,
    output iq_entry_t                           issue_entry,
    output logic                                iq_full,
    output logic [$clog2(IQ_DEPTH+1)-1:0]       count
);

    localparam int IW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int CW = $clog2(IQ_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);
    // Full leaves room for one whole dispatch group, so dispatch never overflows.
    localparam logic [CW-1:0] FULL_TH = CW'(IQ_DEPTH - FETCH_WIDTH);

    iq_entry_t           ent_q [IQ_DEPTH];
    iq_entry_t           ent_n [IQ_DEPTH];
    logic [IQ_DEPTH-1:0] vld_q, vld_n;
    logic [IQ_DEPTH-1:0] rdy1_q, rdy1_n;
    logic [IQ_DEPTH-1:0] rdy2_q, rdy2_n;
    logic [CW-1:0]       cnt_q, cnt_n;
    logic [CW-1:0]       pos;
    logic [IW-1:0]       wr;

    wake_req_t              wake [ALU_WAKE_NUM];
    logic [FETCH_WIDTH-1:0] disp_hit1, disp_hit2;

    logic [IQ_DEPTH-1:0] eligible;
    logic [IW-1:0]       sel_idx;
    logic                sel_found;
    logic                do_issue;

    // ------------------------------------------------------------------
    // Wakeup bundle and ready lookup for dispatching slots
    // ------------------------------------------------------------------
    always_comb begin
        for (int w = 0; w < ALU_WAKE_NUM; w++) begin
            wake[w].valid = wake_valid[w];
            wake[w].preg  = wake_preg[w];
        end
    end

    always_comb begin
        disp_hit1 = '0;
        disp_hit2 = '0;
        for (int s = 0; s < FETCH_WIDTH; s++) begin
            rdy_psrc1[s] = disp_entry[s].psrc1.id;
            rdy_psrc2[s] = disp_entry[s].psrc2.id;
            for (int w = 0; w < ALU_WAKE_NUM; w++) begin
                if (wake[w].valid) begin
                    if (disp_entry[s].psrc1.id == wake[w].preg) disp_hit1[s] = 1'b1;
                    if (disp_entry[s].psrc2.id == wake[w].preg) disp_hit2[s] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Select (stored state only; a wake this cycle counts from next cycle)
    // ------------------------------------------------------------------
    assign eligible = vld_q & rdy1_q & rdy2_q;

    iq_select #(.N(IQ_DEPTH)) u_select (
        .eligible (eligible),
        .idx      (sel_idx),
        .found    (sel_found)
    );

    assign issue_valid = sel_found;
    assign issue_entry = ent_q[sel_idx];
    assign do_issue    = sel_found && issue_ready;
    assign iq_full     = (cnt_q > FULL_TH);
    assign count       = cnt_q;

    // ------------------------------------------------------------------
    // Next state: shift out the issued entry, wake, append, then flush
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) ent_n[i] = ent_q[i];
        vld_n  = vld_q;
        rdy1_n = rdy1_q;
        rdy2_n = rdy2_q;
        cnt_n  = cnt_q;
        pos    = '0;
        wr     = '0;

        if (do_issue) begin
            for (int i = 0; i < IQ_DEPTH - 1; i++) begin
                if (i >= int'(sel_idx)) begin
                    ent_n[i]  = ent_q[i+1];
                    vld_n[i]  = vld_q[i+1];
                    rdy1_n[i] = rdy1_q[i+1];
                    rdy2_n[i] = rdy2_q[i+1];
                end
            end
            // The top slot always vacates because the queue shrinks by one.
            vld_n[IQ_DEPTH-1]  = 1'b0;
            rdy1_n[IQ_DEPTH-1] = 1'b0;
            rdy2_n[IQ_DEPTH-1] = 1'b0;
            cnt_n = cnt_q - CW'(1);
        end

        for (int i = 0; i < IQ_DEPTH; i++) begin
            for (int w = 0; w < ALU_WAKE_NUM; w++) begin
                if (wake[w].valid && vld_n[i]) begin
                    if (ent_n[i].psrc1.id == wake[w].preg) rdy1_n[i] = 1'b1;
                    if (ent_n[i].psrc2.id == wake[w].preg) rdy2_n[i] = 1'b1;
                end
            end
        end

        // Valid slots are packed in slot order; an idle slot takes no space.
        pos = cnt_n;
        if (!iq_full && !flush) begin
            for (int s = 0; s < FETCH_WIDTH; s++) begin
                if (disp_valid[s] && (pos < DEPTH_C)) begin
                    wr         = pos[IW-1:0];
                    ent_n[wr]  = disp_entry[s];
                    vld_n[wr]  = 1'b1;
                    rdy1_n[wr] = !disp_entry[s].psrc1.valid || rdy_v1[s] || disp_hit1[s];
                    rdy2_n[wr] = !disp_entry[s].psrc2.valid || rdy_v2[s] || disp_hit2[s];
                    pos        = pos + CW'(1);
                end
            end
            cnt_n = pos;
        end

        if (flush) begin
            vld_n  = '0;
            rdy1_n = '0;
            rdy2_n = '0;
            cnt_n  = '0;
        end
    end

    // ------------------------------------------------------------------
    // State registers (payload needs no reset: it is qualified by valid)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_n;
            rdy1_q <= rdy1_n;
            rdy2_q <= rdy2_n;
            cnt_q  <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < IQ_DEPTH; i++) ent_q[i] <= ent_n[i];
    end

endmodule
